// File: rtl/branch_predictor_bht.sv
// Fetch-side beq predictor using a table of 2-bit saturating counters.
// The table is trained from the resolved branch, and the block also produces the redirect PC and saturating event counters.
module branch_predictor_bht #(
    parameter int         XLEN       = 32,
    parameter int         DEPTH      = 64,
    parameter logic [1:0] INIT_STATE = 2'b01,
    parameter int         CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bp_enable,
    input  logic [XLEN-1:0]  pc_if,
    input  logic [31:0]      instr_if,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             upd_valid,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic             upd_pred_taken,
    input  logic [XLEN-1:0]  upd_target,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [5:0] OP_BEQ = 6'b000100;

    generate
        if (DEPTH < 2 || DEPTH > 1024 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("branch_predictor_bht: DEPTH must be a power of two in 2..1024");
        end
    endgenerate

    logic [1:0]       bht_q [DEPTH];
    logic [1:0]       bht_d [DEPTH];
    logic [CNT_W-1:0] branch_count_q, branch_count_d;
    logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

    logic [IDX_W-1:0] idx_if;
    logic [IDX_W-1:0] idx_upd;
    logic             is_beq;
    logic [XLEN-1:0]  pc_if_plus4;
    logic [XLEN-1:0]  upd_pc_plus4;
    logic [XLEN-1:0]  br_offset;
    logic             unused_instr;

    assign idx_if       = pc_if[IDX_W+1:2];
    assign idx_upd      = upd_pc[IDX_W+1:2];
    assign is_beq       = (instr_if[31:26] == OP_BEQ);
    assign pc_if_plus4  = pc_if + XLEN'(4);
    assign upd_pc_plus4 = upd_pc + XLEN'(4);
    assign br_offset    = {{(XLEN-18){instr_if[15]}}, instr_if[15:0], 2'b00};
    assign unused_instr = ^instr_if[25:16];

    // Read the registered table, so a same-cycle update is seen one cycle later.
    always_comb begin
        pred_taken  = bp_enable & is_beq & bht_q[idx_if][1];
        pred_target = pred_taken ? (pc_if_plus4 + br_offset) : pc_if_plus4;
    end

    always_comb begin
        mispredict  = upd_valid & (upd_taken != upd_pred_taken);
        redirect_pc = (upd_valid & upd_taken) ? upd_target : upd_pc_plus4;
    end

    always_comb begin
        bht_d = bht_q;
        if (upd_valid) begin
            if (upd_taken) begin
                if (bht_q[idx_upd] != 2'b11) begin
                    bht_d[idx_upd] = bht_q[idx_upd] + 2'b01;
                end
            end else begin
                if (bht_q[idx_upd] != 2'b00) begin
                    bht_d[idx_upd] = bht_q[idx_upd] - 2'b01;
                end
            end
        end
    end

    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (upd_valid && branch_count_q != {CNT_W{1'b1}}) begin
            branch_count_d = branch_count_q + CNT_W'(1);
        end
        if (mispredict && mispredict_count_q != {CNT_W{1'b1}}) begin
            mispredict_count_d = mispredict_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                bht_q[i] <= INIT_STATE;
            end
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            bht_q              <= bht_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule
